// File: rtl/uvme_reset_st_pulse_gen.sv
// ----------------------------------------------------------------------------
// uvme_reset_st_pulse_gen
//
// Drive-side reset pulse generator. After its own reset is released it emits
// a power-on reset pulse of POR_CYCLES cycles. After that it accepts pulse
// requests over a valid/ready handshake and drives an active-high reset
// (plus its active-low copy) for max(req_width, MIN_CYCLES) cycles.
//
// Optional feature macro: UVME_RESET_ST_PULSE_GEN_ABORT_EN
//   When defined, this adds the input 'abort'. A high 'abort' during a
//   requested pulse ends that pulse on the next cycle. The aborted pulse is
//   still reported with 'done' and is still counted.
//
// Ports
//   clk          in   sole clock
//   reset        in   asynchronous, active-high reset
//   req_valid    in   pulse request valid
//   req_width    in   requested pulse length in cycles (sampled on accept)
//   abort        in   (ABORT_EN only) terminate the pulse in progress
//   req_ready    out  high in IDLE; a request is accepted on valid & ready
//   rst_out      out  generated reset, active-high
//   rst_n_out    out  registered complement of rst_out
//   busy         out  high whenever the generator is not IDLE
//   done         out  one-cycle pulse on the cycle rst_out falls
//   pulse_count  out  completed pulses (POR included), wraps silently
// ----------------------------------------------------------------------------
module uvme_reset_st_pulse_gen #(
  parameter int WIDTH_W    = 16,
  parameter int MIN_CYCLES = 2,
  parameter int POR_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [WIDTH_W-1:0] req_width,
`ifdef UVME_RESET_ST_PULSE_GEN_ABORT_EN
  input  logic               abort,
`endif
  output logic               req_ready,
  output logic               rst_out,
  output logic               rst_n_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pulse_count
);

  typedef enum logic [1:0] {
    ST_POR    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ASSERT = 2'd2
  } state_t;

  localparam logic [WIDTH_W-1:0] POR_LOAD = WIDTH_W'(POR_CYCLES - 1);
  localparam logic [WIDTH_W-1:0] MIN_LEN  = WIDTH_W'(MIN_CYCLES);

  state_t               state_q, state_d;
  logic [WIDTH_W-1:0]   cnt_q, cnt_d;
  logic                 rst_out_q, rst_out_d;
  logic                 rst_n_out_q, rst_n_out_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     pulse_count_q, pulse_count_d;
  logic                 abort_hit;

`ifdef UVME_RESET_ST_PULSE_GEN_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_POR;
      cnt_q         <= POR_LOAD;
      rst_out_q     <= 1'b1;
      rst_n_out_q   <= 1'b0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      pulse_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rst_out_q     <= rst_out_d;
      rst_n_out_q   <= rst_n_out_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  // Next-state and cycle counter. cnt holds the remaining high cycles minus
  // one, so the pulse ends on the edge where cnt is already zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_POR: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_IDLE: begin
        // req_ready_q is high exactly while in IDLE.
        if (req_valid && req_ready_q) begin
          state_d = ST_ASSERT;
          cnt_d   = ((req_width < MIN_LEN) ? MIN_LEN : req_width) - 1'b1;
        end
      end
      ST_ASSERT: begin
        if (abort_hit || cnt_q == '0) state_d = ST_IDLE;
        else                          cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = POR_LOAD;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so they register in step
  // with it. done marks every return to IDLE, which also drives the counter.
  always_comb begin
    rst_out_d     = (state_d != ST_IDLE);
    rst_n_out_d   = (state_d == ST_IDLE);
    req_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    pulse_count_d = pulse_count_q + CNT_W'(done_d);
  end

  assign rst_out     = rst_out_q;
  assign rst_n_out   = rst_n_out_q;
  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_count = pulse_count_q;

endmodule
